// File: rtl/axis_frame_monitor_if.sv
// axis_frame_monitor_if: AXI4-Stream video bus between pixel source and frame monitor.
interface axis_frame_monitor_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_frame_monitor.sv
// axis_frame_monitor: AXI4-Stream video sink checking SOF/EOL framing with backpressure and timeout counters.
// Optional AXIS_FRAME_MON_CHECKSUM_EN adds a per-frame tdata sum on frame_checksum.
module axis_frame_monitor #(
    parameter int          X_SIZE    = 480,
    parameter int          Y_SIZE    = 480,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 1000,
    parameter logic [32:0] PRBS_SEED = 33'h04A4C_B2CA
) (
    input  logic                in_stream_aclk,
    input  logic                periph_resetn,
    axis_frame_monitor_if.slave in_stream,
    input  logic [1:0]          ready_mode,
    output logic [15:0]         x_pos,
    output logic [15:0]         y_pos,
    output logic                locked,
    output logic [15:0]         frame_count,
    output logic [15:0]         sof_err_count,
    output logic [15:0]         eol_err_count,
    output logic [15:0]         timeout_count,
    output logic                err_pulse,
    output logic                frame_done,
    output logic [DATA_W-1:0]   frame_checksum
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {HUNT, ACTIVE} state_t;

    state_t        state, state_n;
    logic          tready_r, ready_n;
    logic [32:0]   prbs;
    logic [TW-1:0] to_cnt;
    logic          beat, proc, sof_exp, last_word, last_line, line_end;
    logic          sof_err, eol_err, frame_start, done, to_hit;
    logic [15:0]   xa, ya, x_n, y_n;
    logic          unused_in;

    assign in_stream.tready = tready_r;
    assign unused_in = ^{in_stream.tkeep, in_stream.tdata};

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) state <= HUNT;
        else                state <= state_n;
    end

    // HUNT keeps x/y at 0, so the SOF beat that locks is treated as word 0 of line 0
    always_comb begin
        beat        = in_stream.tvalid & tready_r;
        proc        = beat & (state == ACTIVE | in_stream.tuser);
        sof_exp     = x_pos == 16'd0 && y_pos == 16'd0;
        xa          = in_stream.tuser ? 16'd0 : x_pos;
        ya          = in_stream.tuser ? 16'd0 : y_pos;
        last_word   = xa == 16'(X_SIZE - 1);
        last_line   = ya == 16'(Y_SIZE - 1);
        line_end    = last_word | in_stream.tlast;
        sof_err     = proc & (sof_exp ^ in_stream.tuser);
        eol_err     = proc & (last_word ^ in_stream.tlast);
        frame_start = proc & in_stream.tuser;
        done        = proc & line_end & last_line;
        x_n         = !proc ? x_pos : line_end ? 16'd0 : xa + 16'd1;
        y_n         = !proc ? y_pos : !line_end ? ya : last_line ? 16'd0 : ya + 16'd1;
        state_n     = proc ? ACTIVE : state;
        to_hit      = ~in_stream.tvalid & (to_cnt == TW'(TIMEOUT - 1));
        ready_n     = ready_mode == 2'd0 ? 1'b1 :
                      ready_mode == 2'd1 ? prbs[32] :
                      ready_mode == 2'd2 ? in_stream.tvalid & ~tready_r : 1'b0;
    end

    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            x_pos         <= '0;
            y_pos         <= '0;
            locked        <= 1'b0;
            frame_count   <= '0;
            sof_err_count <= '0;
            eol_err_count <= '0;
            timeout_count <= '0;
            err_pulse     <= 1'b0;
            frame_done    <= 1'b0;
            tready_r      <= 1'b0;
            prbs          <= PRBS_SEED;
            to_cnt        <= '0;
        end else begin
            x_pos         <= x_n;
            y_pos         <= y_n;
            locked        <= locked | frame_start;
            frame_count   <= frame_count + 16'(frame_start);
            sof_err_count <= sat_inc(sof_err_count, sof_err);
            eol_err_count <= sat_inc(eol_err_count, eol_err);
            timeout_count <= sat_inc(timeout_count, to_hit);
            err_pulse     <= sof_err | eol_err | to_hit;
            frame_done    <= done;
            tready_r      <= ready_n;
            prbs          <= ready_mode == 2'd1 ? {prbs[31:0], prbs[32] ^ ~prbs[19]} : prbs;
            to_cnt        <= (in_stream.tvalid | to_hit) ? '0 : to_cnt + 1'b1;
        end
    end

`ifdef AXIS_FRAME_MON_CHECKSUM_EN
    logic [DATA_W-1:0] acc, acc_n;

    assign acc_n = (frame_start ? '0 : acc) + in_stream.tdata;

    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            acc            <= '0;
            frame_checksum <= '0;
        end else begin
            if (proc) acc <= acc_n;
            if (done) frame_checksum <= acc_n;
        end
    end
`else
    assign frame_checksum = '0;
`endif
endmodule

// File: tb/tb_axis_frame_monitor.sv
// tb_axis_frame_monitor: directed framing vectors with a beat scoreboard on a 4x2 geometry.
module tb_axis_frame_monitor;
    localparam int XS = 4, YS = 2, DW = 32, TO = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   x_pos, y_pos, frame_count, sof_err_count, eol_err_count, timeout_count;
    logic          locked, err_pulse, frame_done;
    logic [DW-1:0] frame_checksum;

    typedef struct {
        logic [15:0] x, y, fc, se, ee;
        logic        fd, ep, lk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    axis_frame_monitor_if #(.DATA_W(DW)) s_if ();

    axis_frame_monitor #(.X_SIZE(XS), .Y_SIZE(YS), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .in_stream_aclk (clk),
        .periph_resetn  (rst_n),
        .in_stream      (s_if),
        .ready_mode     (mode),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .locked         (locked),
        .frame_count    (frame_count),
        .sof_err_count  (sof_err_count),
        .eol_err_count  (eol_err_count),
        .timeout_count  (timeout_count),
        .err_pulse      (err_pulse),
        .frame_done     (frame_done),
        .frame_checksum (frame_checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change only on negedges; a beat is latched at negedge+1 and its effect checked at posedge+1
    initial begin : monitor
        logic pend;
        exp_t e;
        forever begin
            @(negedge clk);
            #1 pend = s_if.tvalid && s_if.tready && rst_n;
            @(posedge clk);
            #1;
            if (pend) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("x_pos", x_pos, e.x);
                    chk("y_pos", y_pos, e.y);
                    chk("frame_count", frame_count, e.fc);
                    chk("sof_err_count", sof_err_count, e.se);
                    chk("eol_err_count", eol_err_count, e.ee);
                    chk("frame_done", frame_done, e.fd);
                    chk("err_pulse", err_pulse, e.ep);
                    chk("locked", locked, e.lk);
                end
            end
        end
    end

    task automatic send(input logic u, input logic l, input logic [31:0] d,
                        input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] fc,
                        input logic [15:0] se, input logic [15:0] ee,
                        input logic fd, input logic ep, input logic lk);
        int n = 0;
        exp_t e;
        e.x = ex; e.y = ey; e.fc = fc; e.se = se; e.ee = ee; e.fd = fd; e.ep = ep; e.lk = lk;
        sb.push_back(e);
        s_if.tuser = u; s_if.tlast = l; s_if.tdata = d; s_if.tvalid = 1'b1;
        while (!s_if.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_if.tready) begin
            chk("ready_wait", 0, 1);
            void'(sb.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] fc, input logic [15:0] se, input logic [15:0] ee);
        for (int ln = 0; ln < YS; ln++)
            for (int w = 0; w < XS; w++)
                send(ln == 0 && w == 0, w == XS - 1, 32'(ln * XS + w),
                     w == XS - 1 ? 16'd0 : 16'(w + 1),
                     w == XS - 1 ? 16'((ln + 1) % YS) : 16'(ln),
                     fc, se, ee, ln == YS - 1 && w == XS - 1, 1'b0, 1'b1);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_x"}, x_pos, 0);
        chk({tag, "_y"}, y_pos, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fc"}, frame_count, 0);
        chk({tag, "_se"}, sof_err_count, 0);
        chk({tag, "_ee"}, eol_err_count, 0);
        chk({tag, "_to"}, timeout_count, 0);
        chk({tag, "_ep"}, err_pulse, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_cs"}, frame_checksum, 0);
        chk({tag, "_tready"}, s_if.tready, 0);
    endtask

    initial begin
        int hi = 0, lo = 0, np = 0;
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '1;
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_mode0", s_if.tready, 1);
        // two clean frames
        frame(16'd1, 16'd0, 16'd0);
        frame(16'd2, 16'd0, 16'd0);
        idle();
        chk("two_frames_fc", frame_count, 2);
        // beats before SOF are dropped
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        repeat (3) send(1'b0, 1'b0, 32'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        frame(16'd1, 16'd0, 16'd0);
        // early tlast on word 1 of line 0
        send(1'b1, 1'b0, 32'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 32'd1, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 32'd2, 16'd1, 16'd1, 16'd2, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd3, 16'd2, 16'd1, 16'd2, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd4, 16'd3, 16'd1, 16'd2, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 32'd5, 16'd0, 16'd0, 16'd2, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        // unexpected tuser on word 2 of line 1 realigns to a new frame
        send(1'b1, 1'b0, 32'd0, 16'd1, 16'd0, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd2, 16'd0, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd3, 16'd0, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 32'd0, 16'd0, 16'd1, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd1, 16'd1, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd2, 16'd1, 16'd3, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 32'd0, 16'd1, 16'd0, 16'd4, 16'd1, 16'd1, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd2, 16'd0, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd3, 16'd0, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 32'd0, 16'd0, 16'd1, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd1, 16'd1, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd2, 16'd1, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd3, 16'd1, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 32'd0, 16'd0, 16'd0, 16'd4, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        // PRBS backpressure
        idle();
        mode = 2'd1;
        repeat (64) begin
            @(negedge clk);
            if (s_if.tready) hi++;
            else lo++;
        end
        chk("prbs_has_high", hi > 0, 1);
        chk("prbs_has_low", lo > 0, 1);
        frame(16'd5, 16'd1, 16'd1);
        frame(16'd6, 16'd1, 16'd1);
        idle();
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
        chk("checksum", frame_checksum, 28);
`else
        chk("checksum", frame_checksum, 0);
`endif
        // ready after valid
        mode = 2'd2;
        frame(16'd7, 16'd1, 16'd1);
        // never ready, then timeout over 2500 idle cycles
        mode = 2'd3;
        idle();
        chk("ready_mode3", s_if.tready, 0);
        repeat (2500) begin
            @(negedge clk);
            if (err_pulse) np++;
        end
        chk("timeout_pulses", np, 2);
        chk("timeout_count", timeout_count, 2);
        chk("timeout_no_sof_err", sof_err_count, 1);
        // reset mid-frame
        mode = 2'd0;
        @(negedge clk);
        send(1'b1, 1'b0, 32'd0, 16'd1, 16'd0, 16'd8, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'd0, 16'd2, 16'd0, 16'd8, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        idle();
        chk("mid_locked", locked, 1);
        rst_n = 1'b0;
        #1;
        all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_frame_monitor.md
Name: axis_frame_monitor

Overview:
- Synthesizable AXI4-Stream video sink at the receiving end of the pixel generator output stream.
- Generates tready with a selectable backpressure pattern.
- Tracks word and line position, and checks start-of-frame (tuser) and end-of-line (tlast) framing against a fixed geometry.
- Exposes frame, error and timeout counters for on-chip bring-up and for closed-loop checks in simulation.

Parameters:
X_SIZE, 480, words per line (words = pixels*3/4)
Y_SIZE, 480, lines per frame
DATA_W, 32, tdata width
TIMEOUT, 1000, consecutive cycles with tvalid low before a timeout error
PRBS_SEED, 33'h04A4C_B2CA, nonzero reset value of the 33-bit ready LFSR

Ports:
in_stream_aclk  input  1  clock
periph_resetn  input  1  async active-low reset
in_stream_tdata  input  DATA_W  stream data
in_stream_tkeep  input  DATA_W/8  byte enables (ignored)
in_stream_tlast  input  1  end of line
in_stream_tuser  input  1  start of frame
in_stream_tvalid  input  1  source valid
in_stream_tready  output  1  sink ready (registered)
ready_mode  input  2  0 always, 1 PRBS, 2 after-valid, 3 never
x_pos  output  16  current word index in line
y_pos  output  16  current line index
locked  output  1  high once first SOF seen
frame_count  output  16  frames started (wraps)
sof_err_count  output  16  missing + unexpected SOF (saturating)
eol_err_count  output  16  missing + unexpected EOL (saturating)
timeout_count  output  16  timeout events (saturating)
err_pulse  output  1  one-cycle pulse when any error is counted
frame_done  output  1  one-cycle pulse on EOL of line Y_SIZE-1
frame_checksum  output  DATA_W  see Optional Feature

Behaviour:
- Clock and reset: one clock, in_stream_aclk. periph_resetn is asynchronous and active-low.
- Reset values: all outputs 0; LFSR = PRBS_SEED; state = HUNT. Reset asserted mid-frame returns to HUNT.
- Beat definition: a beat is tvalid&tready sampled at a rising edge. All counters, positions and pulses update on that edge and are visible the following cycle.
- Ready generation (registered, takes effect one cycle after ready_mode changes):
  - Mode 0: tready=1.
  - Mode 1: LFSR shifts every cycle, next = {prbs[31:0], prbs[32] ^ ~prbs[19]}; tready = prbs[32].
  - Mode 2: tready <= tvalid & ~(tvalid & tready), i.e. asserts the cycle after valid is seen and drops after each beat.
  - Mode 3: tready=0.
- State HUNT:
  - Beats without tuser are dropped silently; no errors counted.
  - A beat with tuser: frame_count++, locked=1, state ACTIVE, then processed as word 0 of line 0.
- State ACTIVE, SOF check (applied first):
  - SOF is expected when x==0 && y==0.
  - Expected and present: frame_count++.
  - Expected and absent: sof_err++.
  - Present but not expected: sof_err++, realign to x=0, y=0, frame_count++, then continue processing the beat.
- State ACTIVE, EOL check (uses x after any realignment):
  - x==X_SIZE-1 with tlast: x=0, y++.
  - x==X_SIZE-1 without tlast: eol_err++, line forced ended (x=0, y++).
  - x<X_SIZE-1 with tlast: eol_err++, x=0, y++.
  - Otherwise: x++.
- Line wrap: when y would reach Y_SIZE, y=0 and frame_done pulses.
- Simultaneous SOF and EOL errors on one beat: both counters increment; one err_pulse.
- Counter widths: error and timeout counters saturate at 16'hFFFF; frame_count wraps.
- Timeout:
  - A cycle counter increments while tvalid=0 and clears while tvalid=1.
  - On reaching TIMEOUT: timeout_count++, err_pulse, counter restarts at 0.
  - Active in both HUNT and ACTIVE states.

Optional Feature:
Macro: AXIS_FRAME_MON_CHECKSUM_EN
- Defined:
  - A DATA_W accumulator is cleared on each frame start.
  - Every ACTIVE beat adds tdata, modulo 2^DATA_W.
  - On frame_done the sum, including the final beat, is latched to frame_checksum and held until the next frame_done.
- Undefined: frame_checksum tied to 0; no accumulator logic.

Test Plan:
- X_SIZE=4, Y_SIZE=2, mode 0, two clean frames (SOF on word 0, tlast on word 3) -> frame_count=2, all error counts 0, frame_done pulses twice, x_pos=0, y_pos=0.
- Mode 0, 3 beats without tuser after reset then a clean frame -> locked rises only at the SOF beat; error counts 0; frame_count=1.
- Mode 0, tlast on word 1 of line 0 -> eol_err_count=1, err_pulse one cycle, y_pos=1, x_pos=0; next 4-word line accepted with no further errors.
- Mode 0, tuser on word 2 of line 1 -> sof_err_count=1, frame_count increments, x_pos=1, y_pos=0 after that beat.
- Mode 1 with default seed, 10 clean frames of 480x480 -> tready toggles pseudo-randomly, frame_count=10, zero errors. With AXIS_FRAME_MON_CHECKSUM_EN and tdata=word index, frame_checksum equals the expected sum.
- tvalid held low for 2500 cycles with TIMEOUT=1000 -> timeout_count=2, two err_pulses; reset asserted mid-frame -> all outputs 0 and locked=0.
